ups_dac_arb: RTL and testbench

UPS_DAC_ARB -- requirements
Module: ups_dac_arb

---
 rtl/ups_pkg.sv | 17 +
 rtl/ups_rr_pick.sv | 39 +++
 rtl/ups_dac_arb.sv | 116 +++++++++++
 tb/tb_ups_dac_arb.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ups_pkg.sv
// Shared types and constants for the UPS DAC write arbiter.
package ups_pkg;

  localparam int unsigned DEF_DAC_W   = 16;
  localparam int unsigned DEF_MIN_GAP = 32;
  localparam int unsigned ID_W        = 3;
  localparam int unsigned GAP_W       = 8;
  localparam int unsigned CNT_W       = 32;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_ISSUE    = 2'd1,
    ARB_GAP      = 2'd2,
    ARB_WAIT_DAC = 2'd3
  } arb_state_t;

endpackage

// File: rtl/ups_rr_pick.sv
// Combinational winner select: round-robin from rr_ptr or fixed lowest-index priority.
module ups_rr_pick
  import ups_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [ID_W-1:0]    rr_ptr,
  input  logic               prio_mode,
  output logic [ID_W-1:0]    winner,
  output logic               any
);

  logic [7:0] elig8;
  logic       found;
  logic [ID_W-1:0] idx;

  assign elig8 = 8'(eligible);
  assign any   = |eligible;

  // First eligible index found in search order wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (prio_mode) begin
        idx = ID_W'(k);
      end else begin
        idx = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
      end
      if (!found && elig8[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ups_dac_arb.sv
// Arbitrates requester writes onto a shared serial DAC with a minimum strobe spacing.
module ups_dac_arb
  import ups_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DAC_W   = DEF_DAC_W,
  parameter int unsigned MIN_GAP = DEF_MIN_GAP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*DAC_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_mask,
  input  logic                     prio_mode,
  input  logic                     dac_busy,
  output logic [DAC_W-1:0]         dac,
  output logic                     dac_dv,
  output logic [ID_W-1:0]          grant_id,
  output logic [CNT_W-1:0]         wr_cnt
);

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 2);

  arb_state_t       state;
  logic [ID_W-1:0]  win_q;
  logic             win_rr_q;
  logic [ID_W-1:0]  rr_ptr;
  logic [GAP_W-1:0] gap_cnt;
  logic [DAC_W-1:0] dac_q;
  logic [ID_W-1:0]  gid_q;

  logic [NUM_REQ-1:0] eligible;
  logic [ID_W-1:0]    pick;
  logic               any_elig;
  logic [7:0]         elig8;
  logic               issue_ok;
  logic [DAC_W-1:0]   data_arr [8];

  assign eligible = req_valid & req_mask;
  assign elig8    = 8'(eligible);

  ups_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr),
    .prio_mode (prio_mode),
    .winner    (pick),
    .any       (any_elig)
  );

  // Unpack request words into a fixed 8-entry array indexed by requester id.
  always_comb begin
    for (int unsigned i = 0; i < 8; i++) data_arr[i] = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) data_arr[i] = req_data[i*DAC_W +: DAC_W];
  end

  // The issue cycle only completes while the registered winner is still asking and unmasked.
  assign issue_ok  = (state == ARB_ISSUE) && elig8[win_q];
  assign req_ready = issue_ok ? (NUM_REQ'(1) << win_q) : '0;
  assign dac_dv    = issue_ok;
  assign dac       = issue_ok ? data_arr[win_q] : dac_q;
  assign grant_id  = issue_ok ? win_q : gid_q;

  // Gap is loaded at selection and decremented through issue, so GAP+WAIT+IDLE+ISSUE spans MIN_GAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      win_q    <= '0;
      win_rr_q <= 1'b0;
      rr_ptr   <= '0;
      gap_cnt  <= '0;
      dac_q    <= '0;
      gid_q    <= '0;
      wr_cnt   <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_elig) begin
            win_q    <= pick;
            win_rr_q <= ~prio_mode;
            gap_cnt  <= GAP_LOAD;
            state    <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (issue_ok) begin
            wr_cnt  <= wr_cnt + 32'd1;
            dac_q   <= data_arr[win_q];
            gid_q   <= win_q;
            gap_cnt <= (gap_cnt == '0) ? '0 : gap_cnt - GAP_W'(1);
            if (win_rr_q) begin
              rr_ptr <= (win_q == ID_W'(NUM_REQ - 1)) ? '0 : win_q + ID_W'(1);
            end
            state <= ARB_GAP;
          end else begin
            gap_cnt <= '0;
            state   <= ARB_IDLE;
          end
        end
        ARB_GAP: begin
          if (gap_cnt <= GAP_W'(1)) begin
            gap_cnt <= '0;
            state   <= ARB_WAIT_DAC;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        ARB_WAIT_DAC: begin
          if (!dac_busy) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ups_dac_arb.sv
// Scoreboard bench for ups_dac_arb: expected strobes queued at stimulus time, popped on dac_dv.
module tb_ups_dac_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [47:0] req_data;
  logic [2:0]  req_ready;
  logic [2:0]  req_mask;
  logic        prio_mode;
  logic        dac_busy;
  logic [15:0] dac;
  logic        dac_dv;
  logic [2:0]  grant_id;
  logic [31:0] wr_cnt;

  typedef struct {
    int unsigned id;
    logic [15:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  logic [2:0]  pend_ack = '0;
  logic [2:0]  kill = '0;
  logic        drop_on_ready;

  ups_dac_arb #(.NUM_REQ(3), .DAC_W(16), .MIN_GAP(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .req_mask  (req_mask),
    .prio_mode (prio_mode),
    .dac_busy  (dac_busy),
    .dac       (dac),
    .dac_dv    (dac_dv),
    .grant_id  (grant_id),
    .wr_cnt    (wr_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
    else n_pass++;
  endtask

  task automatic push(input int unsigned id, input logic [15:0] d, input int unsigned c);
    exp_t e;
    e.id = id; e.data = d; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic set_req(input logic [1:0] i, input logic [15:0] d);
    req_data[32'(i)*16 +: 16] = d;
    req_valid[i] = 1'b1;
  endtask

  // One clock: requesters drop after the acknowledging edge, outputs sampled mid-cycle.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~(pend_ack | kill);
    pend_ack = '0;
    kill = '0;
    @(negedge clk);
    if (dac_dv) begin
      if (sb.size() == 0) begin
        chk("unexp_dv", 32'(dac_dv), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("dv_cyc", cyc, e.cyc);
        chk("grant_id", 32'(grant_id), e.id);
        chk("dac", 32'(dac), 32'(e.data));
        chk("ready", 32'(req_ready), 32'(1) << e.id);
      end
    end
    if (drop_on_ready) pend_ack = req_ready;
  endtask

  task automatic run_to(input int unsigned n);
    while (cyc < n) tick();
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_mask = 3'b111;
    prio_mode = 1'b0; dac_busy = 1'b0; drop_on_ready = 1'b1;

    run_to(2);
    chk("rst_dv", 32'(dac_dv), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_dac", 32'(dac), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_wrcnt", wr_cnt, 0);
    rst = 1'b0;

    // single requester, one-cycle latency
    run_to(10); set_req(2'd0, 16'h1234); push(0, 16'h1234, 11);
    run_to(12);
    chk("wrcnt_first", wr_cnt, 1);
    chk("dac_hold", 32'(dac), 32'h1234);

    run_to(50); rst = 1'b1;
    run_to(52); chk("rrptr_rst", 32'(dut.rr_ptr), 0); rst = 1'b0;

    // round-robin with all requesters held
    run_to(60); drop_on_ready = 1'b0;
    set_req(2'd0, 16'hA000); set_req(2'd1, 16'hA001); set_req(2'd2, 16'hA002);
    push(0, 16'hA000, 61); push(1, 16'hA001, 93); push(2, 16'hA002, 125); push(0, 16'hA000, 157);
    run_to(158); req_valid = '0; drop_on_ready = 1'b1;
    run_to(160); chk("wrcnt_rr", wr_cnt, 4);

    // fixed priority, then mask the favourite
    run_to(200); prio_mode = 1'b1; drop_on_ready = 1'b0;
    set_req(2'd1, 16'hB001); set_req(2'd2, 16'hB002);
    push(1, 16'hB001, 201); push(1, 16'hB001, 233); push(1, 16'hB001, 265);
    run_to(266); req_mask = 3'b101; push(2, 16'hB002, 297);
    run_to(298); req_valid = '0; req_mask = 3'b111; prio_mode = 1'b0; drop_on_ready = 1'b1;
    run_to(300);
    chk("rrptr_fixed", 32'(dut.rr_ptr), 1);
    chk("wrcnt_fixed", wr_cnt, 8);

    // DAC busy long after a grant
    run_to(330); dac_busy = 1'b1; set_req(2'd0, 16'hC000); push(0, 16'hC000, 331);
    run_to(340); set_req(2'd0, 16'hC0DE); push(0, 16'hC0DE, 433);
    run_to(431); dac_busy = 1'b0;
    run_to(434); chk("wrcnt_busy", wr_cnt, 10);

    // reset mid-gap with requester 2 pending
    run_to(470); set_req(2'd0, 16'hD000); push(0, 16'hD000, 471);
    run_to(491);
    chk("gap_at_10", 32'(dut.gap_cnt), 10);
    rst = 1'b1; set_req(2'd2, 16'hD002);
    run_to(492);
    chk("rst2_dv", 32'(dac_dv), 0);
    chk("rst2_ready", 32'(req_ready), 0);
    chk("rst2_dac", 32'(dac), 0);
    chk("rst2_gid", 32'(grant_id), 0);
    chk("rst2_wrcnt", wr_cnt, 0);
    chk("rst2_gap", 32'(dut.gap_cnt), 0);
    run_to(493); rst = 1'b0;
    chk("rst2_rrptr", 32'(dut.rr_ptr), 0);
    push(2, 16'hD002, 494);
    run_to(495); chk("wrcnt_after_rst", wr_cnt, 1);

    // counter wrap
    run_to(530);
    force dut.wr_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.wr_cnt;
    chk("wrcnt_forced", wr_cnt, 32'hFFFF_FFFF);
    run_to(531); set_req(2'd1, 16'hE001); push(1, 16'hE001, 532);
    run_to(533);
    chk("wrcnt_wrap", wr_cnt, 0);
    chk("dac_e001", 32'(dac), 32'hE001);

    // winner withdraws during the issue cycle
    run_to(570); set_req(2'd0, 16'hF000); kill = 3'b001;
    run_to(571);
    chk("abort_dv", 32'(dac_dv), 0);
    chk("abort_ready", 32'(req_ready), 0);
    chk("abort_dac", 32'(dac), 32'hE001);
    run_to(573); chk("abort_wrcnt", wr_cnt, 0);
    run_to(575); set_req(2'd2, 16'hF002); push(2, 16'hF002, 576);
    run_to(577);
    chk("post_abort_wrcnt", wr_cnt, 1);
    chk("post_abort_gid", 32'(grant_id), 2);

    run_to(580);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
